// File: rtl/multi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : multi_pkg
// Purpose  : Shared definitions for the shift-add multiplier controller:
//            the default operand width, the FSM state encoding and a helper
//            that sizes the iteration counter.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package multi_pkg;

  localparam int N_DEFAULT = 4;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CLR  = 3'd1,
    S_LOAD = 3'd2,
    S_ADD  = 3'd3,
    S_SHP  = 3'd4,
    S_SHB  = 3'd5,
    S_DONE = 3'd6
  } state_e;

  // Counter width is clog2(N), kept at least 1 bit so N=1 still elaborates.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/multi_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : multi_ctrl_if
// Purpose  : Bundles the controller's command inputs, the datapath status bit
//            and the datapath strobes.
// Signals  : start, abort       - command inputs to the controller
//            b0                 - current LSB of the datapath B register
//            clr, ld, ldp,
//            shp, shb           - datapath strobes driven by the controller
//            busy, done         - controller status
// Modports : master - controller side; slave - datapath / requester side
// Revision : 1.0 - initial release
// ============================================================================
interface multi_ctrl_if;

  logic start;
  logic abort;
  logic b0;
  logic clr;
  logic ld;
  logic ldp;
  logic shp;
  logic shb;
  logic busy;
  logic done;

  modport master (
    input  start, abort, b0,
    output clr, ld, ldp, shp, shb, busy, done
  );

  modport slave (
    output start, abort, b0,
    input  clr, ld, ldp, shp, shb, busy, done
  );

endinterface
`default_nettype wire

// File: rtl/multi_iter_cnt.sv
`default_nettype none
// ============================================================================
// Module   : multi_iter_cnt
// Purpose  : Iteration counter for the multiplier controller. Clears on
//            request, increments on request and flags the last iteration.
//            Saturates at N-1 so it can never wrap inside an operation.
// Ports    : clk, rst_n (async, active-low)
//            clr_i  - clear to 0 (priority over inc_i)
//            inc_i  - advance one iteration
//            last_o - counter currently equals N-1
// Revision : 1.0 - initial release
// ============================================================================
module multi_iter_cnt
  import multi_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic inc_i,
  output logic last_o
);

  localparam int CW = cnt_width(N);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign last_o = (cnt_q == CW'(N - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !last_o) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/multi_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : multi_ctrl
// Purpose  : Moore FSM sequencing a shift-add multiplier datapath:
//            CLR -> LOAD -> N x (ADD -> SHP -> SHB) -> DONE -> IDLE.
//            Only strobes are produced; the arithmetic lives in the datapath.
// Ports    : clk   - clock, rising edge active
//            rst_n - asynchronous active-low reset
//            bus   - multi_ctrl_if.master (start/abort/b0 in, strobes and
//                    busy/done out)
// Revision : 1.0 - initial release
// ============================================================================
module multi_ctrl
  import multi_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  multi_ctrl_if.master bus
);

  state_e state_q;
  state_e state_d;
  logic   cnt_clr;
  logic   cnt_inc;
  logic   cnt_last;
  logic   busy_w;

  multi_iter_cnt #(
    .N (N)
  ) u_iter_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (cnt_clr),
    .inc_i  (cnt_inc),
    .last_o (cnt_last)
  );

  assign busy_w = (state_q != S_IDLE) && (state_q != S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    case (state_q)
      S_IDLE: if (bus.start) state_d = S_CLR;
      S_CLR:  state_d = S_LOAD;
      S_LOAD: begin
        cnt_clr = 1'b1;
        state_d = S_ADD;
      end
      S_ADD:  state_d = S_SHP;
      S_SHP:  state_d = S_SHB;
      S_SHB: begin
        if (cnt_last) begin
          state_d = S_DONE;
        end else begin
          cnt_inc = 1'b1;
          state_d = S_ADD;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Abort overrides every busy-state transition; IDLE and DONE ignore it.
    if (bus.abort && busy_w) begin
      state_d = S_IDLE;
      cnt_clr = 1'b1;
      cnt_inc = 1'b0;
    end
  end

  // Moore decode; ldp is additionally gated by the multiplier bit in b0.
  assign bus.clr  = (state_q == S_CLR);
  assign bus.ld   = (state_q == S_LOAD);
  assign bus.ldp  = (state_q == S_ADD) && bus.b0;
  assign bus.shp  = (state_q == S_SHP);
  assign bus.shb  = (state_q == S_SHB);
  assign bus.busy = busy_w;
  assign bus.done = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_multi_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_ctrl
// Purpose  : Self-checking bench for multi_ctrl driving a behavioural
//            shift-add datapath. A cycle-level reference model queues the
//            expected product, completion cycle and add pattern per accepted
//            start; a monitor compares them when done is seen.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multi_ctrl;
  import multi_pkg::*;

  localparam int N   = N_DEFAULT;
  localparam int LAT = 2 + 3 * N;
  localparam int PW  = 2 * N + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multi_ctrl_if bus ();

  multi_ctrl #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Behavioural datapath: product accumulates in the upper half, shifts right.
  logic [N-1:0]   da, db, a_q, b_q;
  logic [PW-1:0]  acc;
  logic [2*N-1:0] p;
  assign bus.b0 = b_q[0];
  assign p      = acc[2*N-1:0];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
      acc <= '0;
    end else begin
      if (bus.clr) acc <= '0;
      if (bus.ld) begin
        a_q <= da;
        b_q <= db;
      end
      if (bus.ldp) acc <= acc + (PW'(a_q) << N);
      if (bus.shp) acc <= acc >> 1;
      if (bus.shb) b_q <= b_q >> 1;
    end
  end

  // Reference model: m_rem = cycles left until IDLE (0 idle, 1 done cycle).
  typedef struct {
    int           cyc;
    logic [N-1:0] a;
    logic [N-1:0] b;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   m_rem = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rem <= 0;
      sb.delete();
    end else begin
      cyc <= cyc + 1;
      if (m_rem == 0) begin
        if (bus.start) begin
          sb.push_back('{cyc + 1 + LAT, da, db});
          m_rem <= LAT + 1;
        end
      end else if (m_rem >= 2 && bus.abort) begin
        void'(sb.pop_back());
        m_rem <= 0;
      end else begin
        m_rem <= m_rem - 1;
      end
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor
  initial begin : monitor
    int           it_idx;
    logic [N-1:0] mask;
    exp_t         e;
    it_idx = 0;
    mask   = '0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("busy", 32'(bus.busy), 32'(m_rem >= 2));
        chk("done", 32'(bus.done), 32'(m_rem == 1));
        chk("onehot", 32'($countones({bus.clr, bus.ld, bus.ldp, bus.shp, bus.shb}) <= 1), 32'd1);
        if (bus.clr) begin
          it_idx = 0;
          mask   = '0;
        end
        if (bus.ldp && it_idx < N) mask[it_idx] = 1'b1;
        if (bus.shb) it_idx++;
        if (bus.done) begin
          if (sb.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            chk("done_cycle", 32'(cyc), 32'(e.cyc));
            chk("product", 32'(p), 32'(e.a) * 32'(e.b));
            chk("ldp_iters", 32'(mask), 32'(e.b));
          end
        end
      end
    end
  end

  task automatic start_op(input logic [N-1:0] a, input logic [N-1:0] b);
    da = a;
    db = b;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (m_rem != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic chk_outs_zero(input string name);
    chk(name, 32'({bus.clr, bus.ld, bus.ldp, bus.shp, bus.shb, bus.busy, bus.done}), 32'd0);
  endtask

  initial begin : stim
    int k;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    da = '0;
    db = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_outs_zero("reset_outputs");
    rst_n = 1'b1;
    @(negedge clk);

    // 1011 x 1101 = 143
    start_op(4'b1011, 4'b1101);
    wait_idle();
    chk("p_1011x1101", 32'(p), 32'h8F);

    // 1111 x 0000 = 0, no adds
    start_op(4'b1111, 4'b0000);
    wait_idle();
    chk("p_1111x0000", 32'(p), 32'h00);

    // Start pulsed during SHP of iteration 1 must be ignored.
    start_op(4'd7, 4'd9);
    repeat (6) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);

    // Abort during ADD of iteration 2.
    start_op(4'd6, 4'd5);
    repeat (8) @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk_outs_zero("after_abort");
    repeat (LAT + 3) @(negedge clk);

    // Start held high: back-to-back 15 x 15 = 225 with one IDLE gap.
    da = 4'hF;
    db = 4'hF;
    bus.start = 1'b1;
    for (int op = 0; op < 3; op++) begin
      k = 0;
      while (!bus.done && k < 100) begin
        @(negedge clk);
        k++;
      end
      if (k >= 100) chk("b2b_timeout", 32'd1, 32'd0);
      chk("p_b2b", 32'(p), 32'd225);
      @(negedge clk);
      chk("gap_idle", 32'({bus.busy, bus.clr, bus.done}), 32'd0);
      @(negedge clk);
      chk("gap_clr", 32'(bus.clr), 32'd1);
    end
    bus.start = 1'b0;
    wait_idle();

    // Reset asserted during LOAD, asynchronously between edges.
    start_op(4'd5, 4'd6);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_outs_zero("async_reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_op(4'b0011, 4'b0101);
    wait_idle();
    chk("p_0011x0101", 32'(p), 32'h0F);

    // Randomized operations with start/abort noise.
    for (int t = 0; t < 40; t++) begin
      bus.start = 1'b0;
      bus.abort = 1'b0;
      @(negedge clk);
      wait_idle();
      start_op(N'($urandom), N'($urandom));
      for (int c = 0; c < LAT + 4; c++) begin
        bus.start = ($urandom_range(0, 9) == 0);
        bus.abort = ($urandom_range(0, 11) == 0);
        @(negedge clk);
      end
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
    @(negedge clk);
    wait_idle();
    repeat (3) @(negedge clk);

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multi_ctrl.md
MULTI_CTRL -- requirements
Module: multi_ctrl

Interface
REQ-001 Parameter N, default 4, operand width in bits; it sets the iteration count of the multiplier datapath.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 start  in  1  request a multiply; sampled only in IDLE.
REQ-005 abort  in  1  synchronous cancel of a running operation.
REQ-006 b0  in  1  current LSB of the datapath B register.
REQ-007 clr  out  1  datapath clear strobe.
REQ-008 ld  out  1  datapath operand load strobe (A, B).
REQ-009 ldp  out  1  datapath partial-product load (P <= P + A).
REQ-010 shp  out  1  datapath P shift strobe.
REQ-011 shb  out  1  datapath B shift strobe.
REQ-012 busy  out  1  high in every state except IDLE and DONE.
REQ-013 done  out  1  one-cycle completion pulse.

Function
REQ-014 The FSM SHALL have states IDLE, CLR, LOAD, ADD, SHP, SHB and DONE, with all outputs Moore-decoded from state (plus b0 for ldp).
REQ-015 IDLE: start=1 -> CLR, else stay.
REQ-016 CLR (clr=1) -> LOAD (ld=1) -> ADD.
REQ-017 ADD: ldp = b0, so no P update when b0=0; -> SHP.
REQ-018 SHP (shp=1) -> SHB (shb=1).
REQ-019 SHB: if iteration counter = N-1 -> DONE, else counter+1 and -> ADD.
REQ-020 The iteration counter SHALL be clog2(N) bits, cleared in LOAD, and it SHALL never wrap within an operation.
REQ-021 DONE (done=1) -> IDLE unconditionally, leaving one IDLE cycle before the next CLR even if start is held high.
REQ-022 At most one of clr, ld, ldp, shp, shb SHALL be high in any cycle.
REQ-023 Latency: after the edge that samples start, busy SHALL stay high for 2+3N cycles (14 for N=4), followed by done for exactly 1 cycle.
REQ-024 start outside IDLE SHALL be ignored and SHALL NOT be queued.
REQ-025 abort=1 in any busy state -> IDLE at the next edge; no done pulse; counter cleared.
REQ-026 abort in IDLE or DONE SHALL have no effect.
REQ-027 If start and abort are both high in IDLE, start SHALL win.

Reset
REQ-028 rst_n=0 SHALL immediately force state IDLE, counter 0, and all outputs (clr, ld, ldp, shp, shb, busy, done) to 0, regardless of the clock.
REQ-029 rst_n deasserted mid-operation SHALL resume from IDLE; a new start SHALL work normally.

Structure
REQ-030 The shared package multi_pkg SHALL hold the state encoding constants and the default N.
REQ-031 The iteration counter SHALL be one sub-module, multi_iter_cnt (clear, increment, last flag).
REQ-032 No datapath arithmetic SHALL reside in multi_ctrl; it drives the existing multi datapath strobes only.

Verification
REQ-033 Bench SHALL cover: assert rst_n=0 -> all outputs 0 asynchronously, with no clk edge required.
REQ-034 Bench SHALL cover: multi_ctrl+multi, da=1011, db=1101, start pulse -> ldp in iterations 0, 2, 3 only, done 15 cycles after the start edge, p=8'h8F (143).
REQ-035 Bench SHALL cover: da=1111, db=0000 -> ldp never high, done still at cycle 15, p=8'h00.
REQ-036 Bench SHALL cover: start pulsed during SHP of iteration 1 -> ignored, single done; abort during ADD of iteration 2 -> next cycle IDLE, all strobes 0, no done.
REQ-037 Bench SHALL cover: start held high, da=1111, db=1111 -> back-to-back operations with exactly one IDLE cycle between done and the next clr, p=8'hE1 (225) at each done.
REQ-038 Bench SHALL cover: rst_n low during LOAD, then a fresh start with da=0011, db=0101 -> p=8'h0F (15), correct timing.
